// File: rtl/regfile_sb.sv
// Parametrised register bank: sequential clear walk, pending-write scoreboard and a debug read port.
// Optional macro RF_BYPASS_EN forwards the same-cycle write data and scoreboard retire to rd1/rd2 and busy1/busy2.
module regfile_sb #(
    parameter int unsigned N    = 32,
    parameter int unsigned NREG = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [$clog2(NREG)-1:0]   a1,
    input  logic [$clog2(NREG)-1:0]   a2,
    output logic [N-1:0]              rd1,
    output logic [N-1:0]              rd2,
    input  logic [$clog2(NREG)-1:0]   a3,
    input  logic [N-1:0]              wd3,
    input  logic                      we,
    input  logic                      iss_valid,
    input  logic [$clog2(NREG)-1:0]   iss_rd,
    output logic                      busy1,
    output logic                      busy2,
    output logic                      ready,
    input  logic [$clog2(NREG)-1:0]   dbg_addr,
    output logic [N-1:0]              dbg_data
);
    localparam int unsigned AW = $clog2(NREG);

    typedef enum logic {CLEAR, RUN} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic [NREG-1:0] pend_q, pend_d;
    logic [N-1:0]    regs_q [NREG];
    logic [N-1:0]    regs_d [NREG];
    logic            wr_en;

    assign wr_en = ready_q && we && (a3 != '0);
    assign ready = ready_q;

    // Next state: clear walk, then writeback and scoreboard updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        pend_d  = pend_q;
        regs_d  = regs_q;
        case (state_q)
            CLEAR: begin
                regs_d[cnt_q] = '0;
                cnt_d         = cnt_q + AW'(1);
                if (cnt_q == AW'(NREG - 1)) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                if (wr_en) begin
                    regs_d[a3] = wd3;
                    pend_d[a3] = 1'b0;
                end
                // Issue after retire so a same-edge new producer keeps the bit set.
                if (iss_valid && (iss_rd != '0)) begin
                    pend_d[iss_rd] = 1'b1;
                end
            end
            default: state_d = CLEAR;
        endcase
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            pend_q  <= pend_d;
        end
    end

    // Storage carries no reset; the walk clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            regs_q <= regs_d;
        end
    end

    // Read ports 1 and 2 with scoreboard status.
    always_comb begin
        rd1   = '0;
        rd2   = '0;
        busy1 = ready_q & pend_q[a1];
        busy2 = ready_q & pend_q[a2];
        if (ready_q && (a1 != '0)) rd1 = regs_q[a1];
        if (ready_q && (a2 != '0)) rd2 = regs_q[a2];
`ifdef RF_BYPASS_EN
        if (wr_en && (a1 == a3)) begin
            rd1   = wd3;
            busy1 = iss_valid && (iss_rd == a3);
        end
        if (wr_en && (a2 == a3)) begin
            rd2   = wd3;
            busy2 = iss_valid && (iss_rd == a3);
        end
`endif
    end

    // Debug port never forwards.
    always_comb begin
        dbg_data = '0;
        if (ready_q && (dbg_addr != '0)) dbg_data = regs_q[dbg_addr];
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised self-checking bench for regfile_sb against an architectural model of the bank.
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        rst, we, iss_valid;
    logic [4:0]  a1, a2, a3, iss_rd, dbg_addr;
    logic [31:0] wd3, rd1, rd2, dbg_data;
    logic        busy1, busy2, ready;

    logic        s_rst, s_we, s_iss_valid;
    logic [2:0]  s_a1, s_a2, s_a3, s_iss_rd, s_dbg_addr;
    logic [15:0] s_wd3, s_rd1, s_rd2, s_dbg_data;
    logic        s_busy1, s_busy2, s_ready;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_ready;
    int          m_since;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk(clk), .rst(rst), .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
        .a3(a3), .wd3(wd3), .we(we), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .busy1(busy1), .busy2(busy2), .ready(ready),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    regfile_sb #(.N(16), .NREG(8)) u_small (
        .clk(clk), .rst(s_rst), .a1(s_a1), .a2(s_a2), .rd1(s_rd1), .rd2(s_rd2),
        .a3(s_a3), .wd3(s_wd3), .we(s_we), .iss_valid(s_iss_valid), .iss_rd(s_iss_rd),
        .busy1(s_busy1), .busy2(s_busy2), .ready(s_ready),
        .dbg_addr(s_dbg_addr), .dbg_data(s_dbg_data)
    );

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (!m_ready || a == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
        if (we && a3 != 5'd0 && a == a3) return wd3;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (!m_ready) return 1'b0;
`ifdef RF_BYPASS_EN
        if (we && a3 != 5'd0 && a == a3) return iss_valid && (iss_rd == a3);
`endif
        return m_pend[a];
    endfunction

    function automatic logic [31:0] exp_dbg(input logic [4:0] a);
        if (!m_ready || a == 5'd0) return 32'd0;
        return m_regs[a];
    endfunction

    // Architectural effect of one clock edge; contents are all-zero once a reset walk completes.
    task automatic tick();
        if (rst) begin
            m_ready = 1'b0;
            m_since = 0;
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'd0;
                m_pend[i] = 1'b0;
            end
        end else if (!m_ready) begin
            m_since++;
            if (m_since == 32) m_ready = 1'b1;
        end else begin
            if (we && a3 != 5'd0) begin
                m_regs[a3] = wd3;
                m_pend[a3] = 1'b0;
            end
            if (iss_valid && iss_rd != 5'd0) m_pend[iss_rd] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; iss_valid = 1'b0; a3 = '0; wd3 = '0; iss_rd = '0;
    endtask

    task automatic test_reset();
        int edges;
        rst = 1'b1; idle_inputs(); a1 = 5'd5; a2 = 5'd0; dbg_addr = 5'd5;
        tick();
        vectors++;
        if (ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_ready got %b want 0", ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 40 && !ready; i++) tick();
        we = 1'b1; a3 = 5'd5; wd3 = 32'hDEADBEEF;
        tick();
        idle_inputs(); #1;
        vectors++;
        if (rd1 !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL preload_rd1 got %h want deadbeef", rd1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        edges = 0;
        for (int i = 1; i <= 40; i++) begin
            #1;
            vectors++;
            if (rd1 !== 32'd0 || dbg_data !== 32'd0 || ready !== 1'b0) begin
                miscompares++;
                $display("FAIL walk_outputs rd1 %h dbg %h ready %b want 0", rd1, dbg_data, ready);
            end
            tick();
            if (ready) begin edges = i; break; end
        end
        vectors++;
        if (edges !== 32) begin
            miscompares++; $display("FAIL walk_length got %0d edges want 32", edges);
        end
        vectors++;
        if (rd1 !== 32'd0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
            miscompares++;
            $display("FAIL post_walk rd1 %h busy %b%b want 0 00", rd1, busy1, busy2);
        end
    endtask

    task automatic test_write_read();
        we = 1'b1; a3 = 5'd7; wd3 = 32'h12345678; a1 = 5'd0;
        tick();
        idle_inputs(); a1 = 5'd7; #1;
        vectors++;
        if (rd1 !== 32'h12345678) begin
            miscompares++; $display("FAIL write_read rd1 got %h want 12345678", rd1);
        end
        we = 1'b1; a3 = 5'd0; wd3 = 32'hFFFFFFFF;
        tick();
        idle_inputs(); a2 = 5'd0; #1;
        vectors++;
        if (rd2 !== 32'd0) begin
            miscompares++; $display("FAIL x0_write rd2 got %h want 0", rd2);
        end
    endtask

    task automatic test_scoreboard();
        a1 = 5'd9; iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        idle_inputs(); #1;
        vectors++;
        if (busy1 !== 1'b1) begin
            miscompares++; $display("FAIL sb_issue busy1 got %b want 1", busy1);
        end
        we = 1'b1; a3 = 5'd9; wd3 = 32'h99;
        tick();
        idle_inputs(); #1;
        vectors++;
        if (busy1 !== 1'b0) begin
            miscompares++; $display("FAIL sb_retire busy1 got %b want 0", busy1);
        end
        iss_valid = 1'b1; iss_rd = 5'd9; we = 1'b1; a3 = 5'd9; wd3 = 32'h9A;
        tick();
        idle_inputs(); #1;
        vectors++;
        if (busy1 !== 1'b1) begin
            miscompares++; $display("FAIL sb_set_wins busy1 got %b want 1", busy1);
        end
        we = 1'b1; a3 = 5'd9;
        tick();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        we = 1'b1; a3 = 5'd3; wd3 = 32'h11;
        tick();
        idle_inputs(); iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        idle_inputs(); a1 = 5'd3; we = 1'b1; a3 = 5'd3; wd3 = 32'hA5A5A5A5; #1;
        vectors++;
        if (rd1 !== exp_rd(5'd3) || busy1 !== exp_busy(5'd3)) begin
            miscompares++;
            $display("FAIL same_cycle rd1 %h busy1 %b want %h %b", rd1, busy1, exp_rd(5'd3), exp_busy(5'd3));
        end
        tick();
        idle_inputs(); #1;
        vectors++;
        if (rd1 !== 32'hA5A5A5A5 || busy1 !== 1'b0) begin
            miscompares++; $display("FAIL after_write rd1 %h busy1 %b want a5a5a5a5 0", rd1, busy1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            a1 = 5'($urandom_range(0, 31)); a2 = 5'($urandom_range(0, 7));
            dbg_addr = 5'($urandom_range(0, 31));
            we = 1'($urandom); a3 = 5'($urandom_range(0, 7)); wd3 = $urandom;
            iss_valid = 1'($urandom); iss_rd = 5'($urandom_range(0, 7));
            if (n % 3 == 0) a1 = a3;
            #1;
            vectors++;
            if (rd1 !== exp_rd(a1) || rd2 !== exp_rd(a2) || busy1 !== exp_busy(a1)
                || busy2 !== exp_busy(a2) || dbg_data !== exp_dbg(dbg_addr) || ready !== m_ready) begin
                miscompares++;
                $display("FAIL random[%0d] rd1 %h/%h rd2 %h/%h busy %b%b/%b%b dbg %h/%h ready %b/%b", n,
                         rd1, exp_rd(a1), rd2, exp_rd(a2), busy1, busy2, exp_busy(a1), exp_busy(a2),
                         dbg_data, exp_dbg(dbg_addr), ready, m_ready);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        int edges;
        we = 1'b1; a3 = 5'd4; wd3 = 32'h55;
        tick();
        idle_inputs(); iss_valid = 1'b1; iss_rd = 5'd4;
        tick();
        idle_inputs(); rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            we = 1'($urandom); a3 = 5'd4; wd3 = $urandom; iss_valid = 1'b1; iss_rd = 5'd4;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        edges = 0;
        for (int i = 1; i <= 40; i++) begin
            we = 1'b1; a3 = 5'd4; wd3 = $urandom; iss_valid = 1'b1; iss_rd = 5'd4;
            tick();
            if (ready) begin edges = i; break; end
        end
        idle_inputs(); a1 = 5'd4; dbg_addr = 5'd4; #1;
        vectors++;
        if (edges !== 32) begin
            miscompares++; $display("FAIL mid_reset_walk got %0d edges want 32", edges);
        end
        vectors++;
        if (rd1 !== 32'd0 || busy1 !== 1'b0 || dbg_data !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_reset_state rd1 %h busy1 %b dbg %h want 0 0 0", rd1, busy1, dbg_data);
        end
    endtask

    task automatic test_param_sweep();
        int edges;
        s_rst = 1'b1; s_we = 1'b0; s_iss_valid = 1'b0; s_a3 = '0; s_wd3 = '0; s_iss_rd = '0;
        @(posedge clk); #1;
        s_rst = 1'b0;
        edges = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (s_ready) begin edges = i; break; end
        end
        vectors++;
        if (edges !== 8) begin
            miscompares++; $display("FAIL small_walk got %0d edges want 8", edges);
        end
        s_we = 1'b1; s_a3 = 3'd7; s_wd3 = 16'hBEEF;
        @(posedge clk); #1;
        s_we = 1'b0; s_dbg_addr = 3'd7; #1;
        vectors++;
        if (s_dbg_data !== 16'hBEEF) begin
            miscompares++; $display("FAIL small_dbg got %h want beef", s_dbg_data);
        end
    endtask

    initial begin
        s_rst = 1'b1; s_we = 1'b0; s_iss_valid = 1'b0; s_a1 = '0; s_a2 = '0; s_a3 = '0;
        s_wd3 = '0; s_iss_rd = '0; s_dbg_addr = '0;
        test_reset();
        test_write_read();
        test_scoreboard();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_param_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor of the single-cycle core's register bank.
- Generalises data width and register count.
- Adds synchronous reset with a sequential clear walk, a pending-write scoreboard for multicycle/pipelined cores, and a muxed debug read port in place of per-register outputs.
- Sits between decode (read/issue) and writeback (write) in the datapath.

Parameters:
N, 32, data width in bits
NREG, 32, number of registers (power of 2, >=2); register 0 hardwired to zero
AW, $clog2(NREG), address width (derived, not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
a1  input  AW  read address port 1
a2  input  AW  read address port 2
rd1  output  N  read data port 1 (combinational)
rd2  output  N  read data port 2 (combinational)
a3  input  AW  write address
wd3  input  N  write data
we  input  1  write enable; also retires the scoreboard entry for a3
iss_valid  input  1  issue strobe: mark iss_rd as pending write
iss_rd  input  AW  destination register of the issued instruction
busy1  output  1  pending write outstanding on a1
busy2  output  1  pending write outstanding on a2
ready  output  1  clear walk complete; bank usable
dbg_addr  input  AW  debug read address
dbg_data  output  N  debug read data (combinational)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. No asynchronous logic.
- FSM states: CLEAR, RUN.
  - rst=1 at an edge: state<=CLEAR, cnt<=0, ready<=0, pending<=all zero. rst mid-CLEAR or mid-RUN restarts the walk from 0.
  - CLEAR, each cycle with rst=0: reg[cnt]<=0, cnt<=cnt+1.
  - When cnt==NREG-1: state<=RUN, ready<=1 on that edge.
  - Walk takes NREG cycles after rst deasserts; ready=1 from the NREG-th edge.
- While ready=0:
  - we and iss_valid ignored.
  - rd1, rd2, dbg_data, busy1, busy2 all drive 0.
- RUN, write:
  - If we=1 and a3!=0: reg[a3]<=wd3 at the edge.
  - Writes to a3=0 are discarded.
- RUN, read:
  - rdX = 0 when aX==0, else reg[aX].
  - Same-cycle read/write of one register returns the old value unless RF_BYPASS_EN.
  - dbg_data follows the same rule on dbg_addr; it never bypasses.
- Scoreboard: pending[NREG-1:0], bit 0 constantly 0.
  - iss_valid=1 and iss_rd!=0: pending[iss_rd]<=1.
  - we=1 and a3!=0: pending[a3]<=0.
  - Same edge, same register (iss_rd==a3): set wins and the bit stays 1, because a new producer was issued.
  - Different registers: both take effect.
  - Re-issue to an already-pending register keeps the bit 1; no counting.
  - we to a non-pending register writes data and leaves the bit 0.
- busyX = pending[aX] (0 for aX==0).
- No overflow or underflow conditions exist; all addresses are in range because NREG is a power of 2.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-to-read forwarding when ready=1, we=1, a3!=0 and aX==a3:
  - rdX = wd3 in the same cycle.
  - busyX = 0, unless iss_valid=1 with iss_rd==a3 in that same cycle, in which case busyX = 1.
- Undefined: rdX returns the stored value (new data visible the cycle after the write edge), and busyX = pending[aX] unmodified.

Test Plan:
- Reset walk: preload reg5=0xDEADBEEF, pulse rst 1 cycle -> ready=0 for exactly 32 edges, then 1; rd1 with a1=5 reads 0x00000000; busy1=busy2=0.
- Write/read, x0: we=1 a3=7 wd3=0x12345678, then a1=7 -> rd1=0x12345678 next cycle. we=1 a3=0 wd3=0xFFFFFFFF -> rd2 with a2=0 reads 0.
- Scoreboard: iss_valid=1 iss_rd=9 -> busy1=1 for a1=9 from next cycle. we=1 a3=9 -> busy1=0 after the edge. With iss_rd=9 and we a3=9 on the same edge -> busy1 remains 1.
- Same-cycle read/write: a1=3, we=1 a3=3 wd3=0xA5A5A5A5, old reg3=0x11 -> rd1=0x11 without RF_BYPASS_EN, 0xA5A5A5A5 with it; busy1 low with bypass when reg3 pending.
- Reset mid-operation: write reg4=0x55, issue rd=4, assert rst during RUN and again at cnt=10 of the walk -> walk restarts, ready rises 32 edges after the last rst, reg4=0, busy for 4 = 0; we/iss_valid driven during CLEAR have no effect.
- Parameter sweep: N=16, NREG=8 -> ready after 8 cycles; write 0xBEEF to reg7 -> dbg_addr=7 gives dbg_data=0xBEEF.
